// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the CDC FIFO read-side blocks: arbiter state
// encoding, counter-width helper and the default FIFO word width.
package cdc_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_BURST = 2'd1;
  localparam arb_state_t ST_DRAIN = 2'd2;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_fifo_read_arbiter_rr_select.sv
// Combinational picker: first asserted request at or after ptr, wrapping
// from NUM_REQ-1 back to 0. Returns a one-hot pick and its index.
module rr_select
  import cdc_fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IW-1:0]      idx
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  logic found;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[wrap_add(ptr, k)]) begin
        found                  = 1'b1;
        pick[wrap_add(ptr, k)] = 1'b1;
        idx                    = wrap_add(ptr, k);
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_read_arbiter.sv
// Burst arbiter for the read port of one CDC FIFO (read-clock domain).
// Define CDC_RD_ARB_FIXED_PRIO_EN for lowest-index-wins selection instead of round-robin.
module cdc_fifo_read_arbiter
  import cdc_fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    rd_ready,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_increment,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy
);

  localparam int IW = cnt_width(NUM_REQ);
  localparam int CW = cnt_width(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  arb_state_t            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IW-1:0]         gidx_q, gidx_d;
  logic [CW-1:0]         burst_count_q, burst_count_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      sel_ptr;
  logic [IW-1:0]      next_ptr;
  logic               req_g, out_taken, burst_end, pop;

`ifdef CDC_RD_ARB_FIXED_PRIO_EN
  assign sel_ptr  = '0;
  assign next_ptr = '0;
`else
  assign sel_ptr  = rr_ptr_q;
  assign next_ptr = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
`endif

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .req  (req),
    .ptr  (sel_ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_comb begin
    req_g     = req[gidx_q];
    out_taken = out_valid_q & rd_ready[gidx_q];
    burst_end = (burst_count_q == MAX_CNT) | !req_g | fifo_empty;
    pop       = (state_q == ST_BURST) & !fifo_empty & req_g &
                (burst_count_q < MAX_CNT) & (!out_valid_q | out_taken);

    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    burst_count_d = burst_count_q;
    rr_ptr_d      = rr_ptr_q;
    out_valid_d   = out_valid_q;
    rd_data_d     = rd_data_q;

    // A pop overrides a consume so the register refills in the same cycle.
    if (pop) begin
      out_valid_d   = 1'b1;
      rd_data_d     = fifo_data;
      burst_count_d = burst_count_q + 1'b1;
    end else if (out_taken) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (|req && !fifo_empty) begin
          state_d       = ST_BURST;
          grant_d       = pick;
          gidx_d        = pick_idx;
          burst_count_d = '0;
        end
      end
      ST_BURST: begin
        if (burst_end) begin
          if (out_valid_d) begin
            state_d = ST_DRAIN;
          end else begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
          end
        end
      end
      ST_DRAIN: begin
        if (out_taken) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      burst_count_q <= '0;
      rr_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      // NOTE: the data register is reset as well because rd_data must read zero after reset.
      rd_data_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      burst_count_q <= burst_count_d;
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign fifo_increment = pop;
  assign grant          = grant_q;
  assign rd_valid       = {NUM_REQ{out_valid_q}} & grant_q;
  assign rd_data        = rd_data_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cdc_fifo_read_arbiter.sv
// Directed bench for cdc_fifo_read_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4)
// with a queue-based FIFO model and hand-derived expectations.
module tb_cdc_fifo_read_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] rd_ready;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_increment;
  logic [3:0] grant;
  logic [3:0] rd_valid;
  logic [7:0] rd_data;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] fifo_q[$];
  logic [3:0] pop_owner[$];
  int         pop_cyc[$];
  logic [3:0] take_owner[$];
  logic [7:0] take_data[$];

  cdc_fifo_read_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .rd_ready       (rd_ready),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_increment (fifo_increment),
    .grant          (grant),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(8'(base + i));
    drive_fifo();
  endtask

  task automatic clear_logs();
    pop_owner.delete();
    pop_cyc.delete();
    take_owner.delete();
    take_data.delete();
  endtask

  // One clock: sample pre-edge strobes, step the edge, apply the FIFO pop.
  task automatic cycle();
    logic       pop_now;
    logic [3:0] g;
    logic [3:0] tk;
    logic [7:0] d;
    #1;
    pop_now = fifo_increment;
    g       = grant;
    tk      = rd_valid & rd_ready;
    d       = rd_data;
    check("inc_while_empty", {31'd0, fifo_increment & fifo_empty}, 32'd0);
    check("valid_onehot", ($countones(rd_valid) <= 1) ? 32'd1 : 32'd0, 32'd1);
    check("valid_in_grant", {28'd0, rd_valid & ~grant}, 32'd0);
    @(posedge clock);
    #1;
    cyc++;
    if (pop_now) begin
      pop_owner.push_back(g);
      pop_cyc.push_back(cyc);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (tk != 4'd0) begin
      take_owner.push_back(tk);
      take_data.push_back(d);
    end
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 20 && grant !== exp; i++) cycle();
    check(tag, {28'd0, grant}, {28'd0, exp});
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req      = 4'd0;
    rd_ready = 4'd0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    fifo_q.delete();
    clear_logs();
    drive_fifo();
  endtask

  logic [3:0] exp_own[10];
  logic [3:0] fair_own[4];

  initial begin
    reset    = 1'b1;
    req      = 4'd0;
    rd_ready = 4'd0;
    drive_fifo();
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_valid", {28'd0, rd_valid}, 32'd0);
    check("rst_data", {24'd0, rd_data}, 32'd0);
    check("rst_inc", {31'd0, fifo_increment}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Ten words shared by requesters 1 and 2, consumers always ready.
`ifdef CDC_RD_ARB_FIXED_PRIO_EN
    exp_own = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
`else
    exp_own = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4, 4'h2, 4'h2};
`endif
    clear_logs();
    load(8'h10, 10);
    req      = 4'b0110;
    rd_ready = 4'b1111;
    run(40);
    check("s1_pops", pop_owner.size(), 10);
    check("s1_takes", take_data.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("s1_pop_owner%0d", i), (i < pop_owner.size()) ? {28'd0, pop_owner[i]} : 32'hdead, {28'd0, exp_own[i]});
      check($sformatf("s1_take_data%0d", i), (i < take_data.size()) ? {24'd0, take_data[i]} : 32'hdead, 32'h10 + i);
      check($sformatf("s1_take_owner%0d", i), (i < take_owner.size()) ? {28'd0, take_owner[i]} : 32'hdead, {28'd0, exp_own[i]});
    end
    if (pop_cyc.size() >= 5) begin
      check("s1_b2b_pops", pop_cyc[3] - pop_cyc[0], 3);
      check("s1_burst_gap", pop_cyc[4] - pop_cyc[3], 3);
    end else begin
      check("s1_pop_cyc_count", pop_cyc.size(), 10);
    end
    req = 4'd0;
    run(3);

    // Reset in the middle of a burst for requester 1.
    clear_logs();
    load(8'h40, 5);
    req      = 4'b0010;
    rd_ready = 4'b0010;
    wait_grant("mid_grant1", 4'b0010);
    run(2);
    check("mid_pops", pop_owner.size(), 2);
    reset = 1'b1;
    #1;
    check("mid_rst_grant", {28'd0, grant}, 32'd0);
    check("mid_rst_valid", {28'd0, rd_valid}, 32'd0);
    check("mid_rst_inc", {31'd0, fifo_increment}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", {24'd0, rd_data}, 32'd0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    req      = 4'b0101;
    rd_ready = 4'b0101;
    wait_grant("mid_regrant0", 4'b0001);

    // Backpressure on requester 0.
    do_reset();
    load(8'h20, 6);
    req      = 4'b0001;
    rd_ready = 4'b0001;
    wait_grant("bp_grant", 4'b0001);
    cycle();
    rd_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", {28'd0, rd_valid}, 32'h1);
      check("bp_data", {24'd0, rd_data}, 32'h20);
      check("bp_inc", {31'd0, fifo_increment}, 32'd0);
      cycle();
    end
    rd_ready = 4'b0001;
    #1;
    check("bp_resume_inc", {31'd0, fifo_increment}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      cycle();
      check("bp_resume_data", {24'd0, rd_data}, 32'h20 + i);
      check("bp_resume_inc", {31'd0, fifo_increment}, (i < 3) ? 32'd1 : 32'd0);
    end
    req = 4'd0;
    run(4);

    // Single word: one pop, drain until consumed, then idle.
    do_reset();
    load(8'h55, 1);
    req      = 4'b1000;
    rd_ready = 4'b0000;
    wait_grant("emp_grant", 4'b1000);
    #1;
    check("emp_inc", {31'd0, fifo_increment}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("emp_valid", {28'd0, rd_valid}, 32'h8);
      check("emp_data", {24'd0, rd_data}, 32'h55);
      check("emp_busy", {31'd0, busy}, 32'd1);
      check("emp_no_inc", {31'd0, fifo_increment}, 32'd0);
    end
    rd_ready = 4'b1000;
    cycle();
    check("emp_idle_grant", {28'd0, grant}, 32'd0);
    check("emp_idle_busy", {31'd0, busy}, 32'd0);
    check("emp_idle_valid", {28'd0, rd_valid}, 32'd0);
    check("emp_pops", pop_owner.size(), 1);
    req = 4'd0;
    run(2);

    // Requester 2 releases early with an unconsumed word.
    do_reset();
    load(8'h30, 6);
    req      = 4'b0100;
    rd_ready = 4'b0100;
    wait_grant("early_grant", 4'b0100);
    run(2);
    check("early_pops", pop_owner.size(), 2);
    req      = 4'b1000;
    rd_ready = 4'b0000;
    #1;
    check("early_inc", {31'd0, fifo_increment}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("early_hold_grant", {28'd0, grant}, 32'h4);
      check("early_hold_valid", {28'd0, rd_valid}, 32'h4);
      check("early_hold_data", {24'd0, rd_data}, 32'h31);
    end
    rd_ready = 4'b0100;
    cycle();
    check("early_release", {28'd0, grant}, 32'd0);
    rd_ready = 4'b1000;
    cycle();
    check("early_next", {28'd0, grant}, 32'h8);
    req = 4'd0;
    run(6);

    // Requesters 0 and 3 compete over a FIFO that stays non-empty.
`ifdef CDC_RD_ARB_FIXED_PRIO_EN
    fair_own = '{4'h1, 4'h1, 4'h1, 4'h1};
`else
    fair_own = '{4'h1, 4'h8, 4'h1, 4'h8};
`endif
    do_reset();
    load(8'h60, 20);
    req      = 4'b1001;
    rd_ready = 4'b1111;
    for (int i = 0; i < 80 && pop_owner.size() < 16; i++) cycle();
    check("fair_pops", (pop_owner.size() >= 16) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < 4; k++)
      check($sformatf("fair_owner%0d", k), (4 * k < pop_owner.size()) ? {28'd0, pop_owner[4 * k]} : 32'hdead, {28'd0, fair_own[k]});
    req = 4'd0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_fifo_read_arbiter.md
Name: cdc_fifo_read_arbiter

Overview:
- Shares the read port of one CDC FIFO, read-clock side, among NUM_REQ consumers.
- Grants whole bursts round-robin.
- Pops the FIFO through its increment/empty interface and moves each word through a one-entry output register with a valid/ready handshake per consumer.
- Sits between the FIFO read-state/RAM and the read-domain consumers.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- DATA_WIDTH, 8: FIFO word width.
- MAX_BURST, 4: maximum words popped per grant (1..255).

Ports:
- clock  in  1: read-domain clock.
- reset  in  1: asynchronous reset, active-high.
- req  in  NUM_REQ: requester i wants data; level-sensitive.
- rd_ready  in  NUM_REQ: requester i accepts rd_data this cycle.
- fifo_empty  in  1: FIFO empty flag.
- fifo_data  in  DATA_WIDTH: word at the current FIFO read address, combinational.
- fifo_increment  out  1: pop strobe to the FIFO.
- grant  out  NUM_REQ: one-hot current owner; all zero when idle.
- rd_valid  out  NUM_REQ: output register holds a word for requester i.
- rd_data  out  DATA_WIDTH: shared output data.
- busy  out  1: a burst is in progress.

Behaviour:
- Reset (async, any time): state=IDLE; grant=0, rd_valid=0, rd_data=0, fifo_increment=0, busy=0, burst_count=0, rr_ptr=0. A word held in the output register is discarded; that FIFO entry is already consumed.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - If any req and !fifo_empty, select the first requester at or after rr_ptr (wrapping NUM_REQ-1 -> 0).
  - Register grant, busy=1, burst_count=0, go to BURST. One cycle of arbitration latency.
  - No pop occurs in IDLE.
- BURST, pop condition:
  - fifo_increment = !fifo_empty & req[g] & (burst_count < MAX_BURST) & (out_empty | out_taken).
  - out_taken = rd_valid[g] & rd_ready[g].
- BURST, on a pop:
  - fifo_data is captured into rd_data and rd_valid[g] is set next cycle; burst_count increments.
  - A pop and a consume in the same cycle keep rd_valid high with the new word (full throughput, 1 word/cycle).
- BURST, on out_taken without a pop: rd_valid[g] clears.
- BURST -> DRAIN: when burst_count reaches MAX_BURST, or req[g] deasserts, or fifo_empty.
  - If the output register is empty at that point, go straight to IDLE instead.
  - A transient fifo_empty still ends the burst; the next arbitration re-grants fairly.
- DRAIN:
  - No pops.
  - Wait for out_taken, then go to IDLE.
  - The output word is held even if req[g] drops; the consumer must still take it.
- On leaving BURST/DRAIN for IDLE:
  - grant=0, busy=0.
  - rr_ptr = g+1, wrapping to 0 after NUM_REQ-1.
- rd_valid is only ever set for the granted index; rd_valid has at most one bit high.
- fifo_increment is never high while fifo_empty=1.
- burst_count width: clog2(MAX_BURST+1).
- rd_ready of non-granted requesters is ignored.

Optional Feature:
- Macro: CDC_RD_ARB_FIXED_PRIO_EN.
- When defined: IDLE selection is fixed priority, with the lowest index winning, and rr_ptr is not used. Bursts still end at MAX_BURST, so requester 0 cannot hold the port for more than one burst at a time but always wins the next arbitration.
- When undefined: round-robin exactly as above.

Decomposition:
- Shared package cdc_fifo_pkg holds:
  - the state enum type (IDLE/BURST/DRAIN);
  - a localparam function for clog2-based counter widths;
  - a default DATA_WIDTH constant shared with the FIFO.
- One natural sub-module: rr_select, a combinational priority-from-pointer picker taking req and rr_ptr and returning a one-hot pick plus an index. The macro switches rr_ptr to constant 0 inside the top level.

Test Plan:
- Reset mid-burst (req[1]=1, 2 words popped): assert reset -> same-cycle grant=0, rd_valid=0, fifo_increment=0; after release, the next grant goes to requester 0 (rr_ptr=0).
- req=4'b0110, FIFO holds 10 words, rd_ready all 1, MAX_BURST=4:
  - requester 1 gets 4 consecutive words (fifo_increment high 4 cycles);
  - IDLE cycle, then requester 2 gets 4 words;
  - then requester 1 gets the remaining 2.
- Backpressure: grant to requester 0, rd_ready[0] low for 3 cycles -> rd_valid[0] and rd_data stable, no fifo_increment during the stall; throughput resumes at 1 word/cycle when ready returns.
- Empty boundary: FIFO holds 1 word, req[3]=1 -> exactly one pop, DRAIN until taken, IDLE; fifo_increment never asserted while fifo_empty=1.
- Early release: req[2] drops after 2 pops, with a word held and rd_ready[2]=0 -> DRAIN holds the word until rd_ready[2]=1, then grant=0; the next grant goes to requester 3.
- With CDC_RD_ARB_FIXED_PRIO_EN, req=4'b1001 continuously and the FIFO always non-empty -> requester 0 is granted every arbitration and requester 3 never is.
